// File: rtl/mbr_sector_parser.sv
// MBR sector parser: fetches one sector, captures the four primary
// partition start LBAs and type bytes, and validates the 55 AA signature.
// Ports: clock/reset; io_Start command; io_Busy status; sector request
// handshake (io_SectorReq/io_SectorLBA/io_SectorAck); byte stream
// (io_DataValid/io_Data/io_DataReady); results io_Done, io_Valid,
// io_Error, io_Partition1Start..io_Partition4Start, io_PartitionTypes.
module mbr_sector_parser #(
    parameter logic [31:0] MBR_LBA        = 32'd0,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_Start,
    output logic        io_Busy,
    output logic        io_SectorReq,
    output logic [31:0] io_SectorLBA,
    input  logic        io_SectorAck,
    input  logic        io_DataValid,
    input  logic [7:0]  io_Data,
    output logic        io_DataReady,
    output logic        io_Done,
    output logic        io_Valid,
    output logic        io_Error,
    output logic [31:0] io_Partition1Start,
    output logic [31:0] io_Partition2Start,
    output logic [31:0] io_Partition3Start,
    output logic [31:0] io_Partition4Start,
    output logic [31:0] io_PartitionTypes
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // Fires on the idle cycle that would bring the counter to TIMEOUT_CYCLES.
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RECV,
        S_COMMIT,
        S_DONE
    } state_t;

    state_t         state;
    logic           busy;
    logic           req;
    logic           ready;
    logic           done;
    logic           valid;
    logic           error;
    logic [31:0]    part_q [4];
    logic [31:0]    types_q;
    logic [31:0]    sh_start [4];
    logic [7:0]     sh_type [4];
    logic           sig_ok;
    logic [9:0]     bcnt;
    logic [TW-1:0]  tcnt;
    logic           accept;

    assign accept = (state == S_RECV) && ready && io_DataValid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            req     <= 1'b0;
            ready   <= 1'b0;
            done    <= 1'b0;
            valid   <= 1'b0;
            error   <= 1'b0;
            types_q <= '0;
            sig_ok  <= 1'b0;
            bcnt    <= '0;
            tcnt    <= '0;
            for (int i = 0; i < 4; i++) begin
                part_q[i]   <= '0;
                sh_start[i] <= '0;
                sh_type[i]  <= '0;
            end
        end else begin
            unique case (state)
                S_IDLE: begin
                    bcnt   <= '0;
                    tcnt   <= '0;
                    sig_ok <= 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        sh_start[i] <= '0;
                        sh_type[i]  <= '0;
                    end
                    if (io_Start) begin
                        state <= S_REQ;
                        busy  <= 1'b1;
                        req   <= 1'b1;
                        valid <= 1'b0;
                        error <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (io_SectorAck) begin
                        state <= S_RECV;
                        req   <= 1'b0;
                        ready <= 1'b1;
                        tcnt  <= '0;
                    end else if (tcnt == T_LAST) begin
                        state   <= S_DONE;
                        req     <= 1'b0;
                        done    <= 1'b1;
                        error   <= 1'b1;
                        valid   <= 1'b0;
                        types_q <= '0;
                        for (int i = 0; i < 4; i++) part_q[i] <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_RECV: begin
                    // An accepted byte always beats a coincident timeout.
                    if (accept) begin
                        tcnt <= '0;
                        bcnt <= bcnt + 10'd1;
                        for (int i = 0; i < 4; i++) begin
                            if (bcnt == 10'(450 + 16 * i))
                                sh_type[i] <= io_Data;
                            for (int j = 0; j < 4; j++)
                                if (bcnt == 10'(454 + 16 * i + j))
                                    sh_start[i][8*j +: 8] <= io_Data;
                        end
                        if (bcnt == 10'd510)
                            sig_ok <= (io_Data == 8'h55);
                        if (bcnt == 10'd511) begin
                            sig_ok <= sig_ok && (io_Data == 8'hAA);
                            state  <= S_COMMIT;
                            ready  <= 1'b0;
                        end
                    end else if (tcnt == T_LAST) begin
                        state   <= S_DONE;
                        ready   <= 1'b0;
                        done    <= 1'b1;
                        error   <= 1'b1;
                        valid   <= 1'b0;
                        types_q <= '0;
                        for (int i = 0; i < 4; i++) part_q[i] <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_COMMIT: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                    if (sig_ok) begin
                        valid   <= 1'b1;
                        types_q <= {sh_type[3], sh_type[2],
                                    sh_type[1], sh_type[0]};
                        for (int i = 0; i < 4; i++) part_q[i] <= sh_start[i];
                    end else begin
                        error   <= 1'b1;
                        types_q <= '0;
                        for (int i = 0; i < 4; i++) part_q[i] <= '0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign io_Busy            = busy;
    assign io_SectorReq       = req;
    assign io_SectorLBA       = MBR_LBA;
    assign io_DataReady       = ready;
    assign io_Done            = done;
    assign io_Valid           = valid;
    assign io_Error           = error;
    assign io_Partition1Start = part_q[0];
    assign io_Partition2Start = part_q[1];
    assign io_Partition3Start = part_q[2];
    assign io_Partition4Start = part_q[3];
    assign io_PartitionTypes  = types_q;

endmodule

// File: tb/tb_mbr_sector_parser.sv
// Testbench for mbr_sector_parser: scenario tasks drive sector streams,
// push expected parse results to a scoreboard and compare at io_Done.
module tb_mbr_sector_parser;

    localparam logic [31:0] TB_LBA = 32'h0000_0007;
    localparam int          TB_TO  = 16;

    localparam logic [31:0] START [4] = '{32'h0000_0800, 32'h0010_0800,
                                          32'h1234_5678, 32'h0000_0000};
    localparam logic [7:0]  TYP [4]   = '{8'h0C, 8'h83, 8'h07, 8'h00};

    typedef struct packed {
        logic            valid;
        logic            error;
        logic [3:0][31:0] p;
        logic [31:0]     types;
    } res_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_Start = 1'b0;
    logic        io_Busy;
    logic        io_SectorReq;
    logic [31:0] io_SectorLBA;
    logic        io_SectorAck = 1'b0;
    logic        io_DataValid = 1'b0;
    logic [7:0]  io_Data = 8'h00;
    logic        io_DataReady;
    logic        io_Done;
    logic        io_Valid;
    logic        io_Error;
    logic [31:0] io_Partition1Start;
    logic [31:0] io_Partition2Start;
    logic [31:0] io_Partition3Start;
    logic [31:0] io_Partition4Start;
    logic [31:0] io_PartitionTypes;

    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    logic [7:0] mbr [512];
    res_t sb [$];

    mbr_sector_parser #(
        .MBR_LBA        (TB_LBA),
        .TIMEOUT_CYCLES (TB_TO)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .io_Start           (io_Start),
        .io_Busy            (io_Busy),
        .io_SectorReq       (io_SectorReq),
        .io_SectorLBA       (io_SectorLBA),
        .io_SectorAck       (io_SectorAck),
        .io_DataValid       (io_DataValid),
        .io_Data            (io_Data),
        .io_DataReady       (io_DataReady),
        .io_Done            (io_Done),
        .io_Valid           (io_Valid),
        .io_Error           (io_Error),
        .io_Partition1Start (io_Partition1Start),
        .io_Partition2Start (io_Partition2Start),
        .io_Partition3Start (io_Partition3Start),
        .io_Partition4Start (io_Partition4Start),
        .io_PartitionTypes  (io_PartitionTypes)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    function automatic void build(input bit bad);
        int b;
        for (int k = 0; k < 512; k++) mbr[k] = k[7:0] ^ 8'h5A;
        for (int i = 0; i < 4; i++) begin
            b = 446 + 16 * i;
            mbr[b + 4] = TYP[i];
            for (int j = 0; j < 4; j++) mbr[b + 8 + j] = START[i][8*j +: 8];
        end
        mbr[510] = 8'h55;
        mbr[511] = bad ? 8'hAB : 8'hAA;
    endfunction

    function automatic res_t exp_for(input bit ok);
        res_t r;
        r = '0;
        r.valid = ok;
        r.error = !ok;
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                r.p[i] = START[i];
                r.types[8*i +: 8] = TYP[i];
            end
        end
        return r;
    endfunction

    function automatic res_t obs();
        res_t r;
        r.valid = io_Valid;
        r.error = io_Error;
        r.p     = {io_Partition4Start, io_Partition3Start,
                   io_Partition2Start, io_Partition1Start};
        r.types = io_PartitionTypes;
        return r;
    endfunction

    // Stimulus only: start, ack after ack_dly cycles, then stream bytes
    // [0, stop_at) with random gaps; start_at re-pulses io_Start mid-stream.
    task automatic drive_parse(input bit bad, input int ack_dly,
                               input int max_gap, input int start_at,
                               input int stop_at, input res_t e,
                               output int last_cyc, output int perr);
        int gap;
        build(bad);
        sb.push_back(e);
        perr = 0;
        last_cyc = 0;
        io_Start = 1'b1;
        @(posedge clock); #1;
        io_Start = 1'b0;
        for (int k = 0; k < ack_dly; k++) begin
            if (io_SectorReq !== 1'b1 || io_DataReady !== 1'b0) perr++;
            @(posedge clock); #1;
        end
        if (io_SectorReq !== 1'b1 || io_DataReady !== 1'b0) perr++;
        io_SectorAck = 1'b1;
        @(posedge clock); #1;
        io_SectorAck = 1'b0;
        for (int idx = 0; idx < stop_at; idx++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (gap) begin
                @(posedge clock); #1;
            end
            if (io_SectorReq !== 1'b0 || io_DataReady !== 1'b1) perr++;
            if (idx == start_at) io_Start = 1'b1;
            io_DataValid = 1'b1;
            io_Data = mbr[idx];
            @(posedge clock); #1;
            io_Start = 1'b0;
            io_DataValid = 1'b0;
            last_cyc = cyc;
        end
    endtask

    task automatic wait_done(output int dcyc);
        dcyc = -1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clock); #1;
            if (io_Done === 1'b1) begin
                dcyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        compared++;
        if (obs() !== res_t'(0)) begin
            mismatched++;
            $display("FAIL reset_results: got %h want 0", obs());
        end
        compared++;
        if ({io_Busy, io_SectorReq, io_DataReady, io_Done} !== 4'b0) begin
            mismatched++;
            $display("FAIL reset_flags: got %b want 0000",
                     {io_Busy, io_SectorReq, io_DataReady, io_Done});
        end
        compared++;
        if (io_SectorLBA !== TB_LBA) begin
            mismatched++;
            $display("FAIL reset_lba: got %h want %h", io_SectorLBA, TB_LBA);
        end
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        compared++;
        if (io_Busy !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_busy: got %b want 0", io_Busy);
        end
    endtask

    task automatic test_valid();
        int last, perr, d;
        res_t e;
        drive_parse(1'b0, 0, 0, -1, 512, exp_for(1'b1), last, perr);
        compared++;
        if (perr !== 0) begin
            mismatched++;
            $display("FAIL valid_handshake: got %0d errs want 0", perr);
        end
        wait_done(d);
        compared++;
        if (d !== last + 1) begin
            mismatched++;
            $display("FAIL valid_latency: got cyc %0d want %0d", d, last + 1);
        end
        e = sb.pop_front();
        compared++;
        if (obs() !== e) begin
            mismatched++;
            $display("FAIL valid_result: got %h want %h", obs(), e);
        end
        compared++;
        if (io_Partition3Start !== 32'h1234_5678) begin
            mismatched++;
            $display("FAIL valid_p3: got %h want 12345678", io_Partition3Start);
        end
        compared++;
        if (io_PartitionTypes !== 32'h0007_830C) begin
            mismatched++;
            $display("FAIL valid_types: got %h want 0007830c", io_PartitionTypes);
        end
        @(posedge clock); #1;
        compared++;
        if ({io_Done, io_Busy, io_DataReady, io_Valid} !== 4'b0001) begin
            mismatched++;
            $display("FAIL valid_after: got %b want 0001",
                     {io_Done, io_Busy, io_DataReady, io_Valid});
        end
    endtask

    task automatic test_bad_sig();
        int last, perr, d;
        res_t e;
        drive_parse(1'b1, 0, 0, -1, 512, exp_for(1'b0), last, perr);
        wait_done(d);
        compared++;
        if (d !== last + 1) begin
            mismatched++;
            $display("FAIL badsig_latency: got cyc %0d want %0d", d, last + 1);
        end
        e = sb.pop_front();
        compared++;
        if (obs() !== e) begin
            mismatched++;
            $display("FAIL badsig_result: got %h want %h", obs(), e);
        end
        @(posedge clock); #1;
        compared++;
        if ({io_Done, io_Error, io_Valid} !== 3'b010) begin
            mismatched++;
            $display("FAIL badsig_hold: got %b want 010",
                     {io_Done, io_Error, io_Valid});
        end
    endtask

    task automatic test_gaps();
        int last, perr, d;
        res_t e;
        drive_parse(1'b0, 5, 5, -1, 512, exp_for(1'b1), last, perr);
        compared++;
        if (perr !== 0) begin
            mismatched++;
            $display("FAIL gaps_handshake: got %0d errs want 0", perr);
        end
        wait_done(d);
        compared++;
        if (d !== last + 1) begin
            mismatched++;
            $display("FAIL gaps_latency: got cyc %0d want %0d", d, last + 1);
        end
        e = sb.pop_front();
        compared++;
        if (obs() !== e) begin
            mismatched++;
            $display("FAIL gaps_result: got %h want %h", obs(), e);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_timeout();
        int last, perr, d;
        res_t e;
        drive_parse(1'b0, 0, 0, -1, 101, exp_for(1'b0), last, perr);
        wait_done(d);
        compared++;
        if (d - last !== TB_TO) begin
            mismatched++;
            $display("FAIL timeout_cycles: got %0d want %0d", d - last, TB_TO);
        end
        e = sb.pop_front();
        compared++;
        if (obs() !== e) begin
            mismatched++;
            $display("FAIL timeout_result: got %h want %h", obs(), e);
        end
        compared++;
        if ({io_SectorReq, io_DataReady} !== 2'b00) begin
            mismatched++;
            $display("FAIL timeout_hs: got %b want 00",
                     {io_SectorReq, io_DataReady});
        end
        @(posedge clock); #1;
        drive_parse(1'b0, 2, 3, -1, 512, exp_for(1'b1), last, perr);
        wait_done(d);
        e = sb.pop_front();
        compared++;
        if (obs() !== e || d !== last + 1) begin
            mismatched++;
            $display("FAIL timeout_recover: got %h @%0d want %h @%0d",
                     obs(), d, e, last + 1);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_start_ignored();
        int last, perr, d;
        res_t e;
        drive_parse(1'b0, 1, 2, 200, 512, exp_for(1'b1), last, perr);
        compared++;
        if (perr !== 0) begin
            mismatched++;
            $display("FAIL start_ign_hs: got %0d errs want 0", perr);
        end
        wait_done(d);
        e = sb.pop_front();
        compared++;
        if (obs() !== e || d !== last + 1) begin
            mismatched++;
            $display("FAIL start_ign_result: got %h @%0d want %h @%0d",
                     obs(), d, e, last + 1);
        end
        @(posedge clock); #1;
        compared++;
        if (io_Busy !== 1'b0) begin
            mismatched++;
            $display("FAIL start_ign_requeue: got busy %b want 0", io_Busy);
        end
    endtask

    task automatic test_reset_mid();
        int last, perr, d;
        res_t e;
        drive_parse(1'b0, 0, 0, -1, 300, exp_for(1'b1), last, perr);
        #3;
        reset = 1'b1;
        #1;
        compared++;
        if (obs() !== res_t'(0) ||
            {io_Busy, io_SectorReq, io_DataReady, io_Done} !== 4'b0) begin
            mismatched++;
            $display("FAIL midreset_clear: got %h/%b want 0/0000", obs(),
                     {io_Busy, io_SectorReq, io_DataReady, io_Done});
        end
        sb.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        drive_parse(1'b0, 0, 1, -1, 512, exp_for(1'b1), last, perr);
        wait_done(d);
        e = sb.pop_front();
        compared++;
        if (obs() !== e || d !== last + 1) begin
            mismatched++;
            $display("FAIL midreset_recover: got %h @%0d want %h @%0d",
                     obs(), d, e, last + 1);
        end
        @(posedge clock); #1;
    endtask

    initial begin
        test_reset();
        test_valid();
        test_bad_sig();
        test_gaps();
        test_timeout();
        test_start_ignored();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
